cache_tag_lookup: RTL and testbench

Parametrised N-way set-associative tag store and hit detector for the CPU's instruction and data caches. It holds tags, valid bits and per-set tree pseudo-LRU state, and returns a registered hit result, hit way and replacement victim one cycle after each lookup. It also accepts line fills, single-set invalidates and a multi-cycle full flush. The cache controller FSM drives it and consumes its response.

---
 rtl/cache_pkg.sv | 54 +++++
 rtl/cache_tag_lookup_plru.sv | 32 +++
 rtl/cache_tag_lookup.sv | 174 +++++++++++++++++
 tb/tb_cache_tag_lookup.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the cache tag store.
package cache_pkg;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fsm_e;

  // Helpers work on vectors sized for the largest legal associativity.
  // Callers zero-extend their tree and way and keep the low bits.
  localparam int MAX_WAYS = 8;
  localparam int MAX_WW   = 3;

  // Number of tree levels (way-index bits) for a given associativity.
  function automatic int plru_levels(input int ways);
    return (ways > 4) ? 3 : (ways > 2) ? 2 : 1;
  endfunction

  // Follow the node pointers from the root; 0 means take the lower half.
  function automatic logic [MAX_WW-1:0] plru_victim(input int ways,
                                                    input logic [MAX_WAYS-2:0] tree);
    logic [3:0]        n;
    logic [MAX_WW-1:0] w;
    n = '0;
    w = '0;
    for (int l = 0; l < MAX_WW; l++) begin
      if (l < plru_levels(ways)) begin
        w = {w[MAX_WW-2:0], tree[n[2:0]]};
        n = {n[2:0], 1'b0} + 4'd1 + {3'b000, tree[n[2:0]]};
      end
    end
    return w;
  endfunction

  // Point every node on the path to `way` toward the other half.
  function automatic logic [MAX_WAYS-2:0] plru_touch(input int ways,
                                                     input logic [MAX_WAYS-2:0] tree,
                                                     input logic [MAX_WW-1:0] way);
    logic [3:0]          n;
    logic [MAX_WW-1:0]   wa;
    logic [MAX_WAYS-2:0] t;
    logic                b;
    n  = '0;
    t  = tree;
    wa = way << (MAX_WW - plru_levels(ways));
    for (int l = 0; l < MAX_WW; l++) begin
      if (l < plru_levels(ways)) begin
        b         = wa[MAX_WW-1];
        t[n[2:0]] = ~b;
        n         = {n[2:0], 1'b0} + 4'd1 + {3'b000, b};
        wa        = wa << 1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cache_tag_lookup_plru.sv
// Combinational tree-PLRU slice: next tree after touching a way, and victim.
module plru_tree
  import cache_pkg::*;
#(
  parameter  int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree,
  input  logic [WAY_W-1:0] way,
  output logic [WAYS-2:0]  tree_nxt,
  output logic [WAY_W-1:0] victim
);

  logic [MAX_WAYS-2:0] t_ext, t_nxt;
  logic [MAX_WW-1:0]   w_ext, v_ext;
  logic                unused_hi;

  // Widen to helper size, evaluate, then narrow back.
  always_comb begin
    t_ext             = '0;
    t_ext[WAYS-2:0]   = tree;
    w_ext             = '0;
    w_ext[WAY_W-1:0]  = way;
    t_nxt             = plru_touch(WAYS, t_ext, w_ext);
    v_ext             = plru_victim(WAYS, t_ext);
  end

  assign tree_nxt  = t_nxt[WAYS-2:0];
  assign victim    = v_ext[WAY_W-1:0];
  assign unused_hi = ^{t_nxt, v_ext};

endmodule

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store with registered hit/victim response,
// line fills, set invalidates and a one-set-per-cycle full flush.
module cache_tag_lookup
  import cache_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 16,
  parameter  int TAG_W = 28,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic [WAY_W-1:0] resp_victim,
  output logic             resp_multi,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_valid,
  input  logic [IDX_W-1:0] inv_index,
  input  logic             flush,
  output logic             busy
);

  logic [TAG_W-1:0]             tags [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]    vld;
  logic [SETS-1:0][WAYS-2:0]    plru;

  fsm_e             state, state_nxt;
  logic [IDX_W-1:0] fl_cnt;

  logic             acc;
  logic [WAYS-1:0]  hit_vec;
  logic             lk_hit, lk_multi, lk_has_inv;
  logic [WAY_W-1:0] lk_way, lk_inv_way, lk_plru_vic, lk_victim;

  // Hit touch is deferred to the response cycle.
  logic             upd_vld;
  logic [IDX_W-1:0] upd_idx;
  logic [WAY_W-1:0] upd_way;

  logic [WAYS-2:0]     hit_tree_nxt, fill_tree_nxt, unused_lk_tree;
  logic [WAY_W-1:0]    unused_fill_vic;
  logic [MAX_WAYS-2:0] ht_in, ht_out;
  logic                unused_ht;

  assign acc = req_valid && req_ready;

  // Tag compare, lowest hit way and lowest invalid way for the requested set.
  always_comb begin
    hit_vec    = '0;
    lk_way     = '0;
    lk_has_inv = 1'b0;
    lk_inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      hit_vec[w] = vld[req_index][w] && (tags[req_index][w] == req_tag);
      if (hit_vec[w]) lk_way = WAY_W'(w);
      if (!vld[req_index][w]) begin
        lk_has_inv = 1'b1;
        lk_inv_way = WAY_W'(w);
      end
    end
    lk_hit    = |hit_vec;
    lk_multi  = (hit_vec & (hit_vec - WAYS'(1))) != '0;
    lk_victim = lk_has_inv ? lk_inv_way : lk_plru_vic;
  end

  plru_tree #(.WAYS(WAYS)) u_lk_plru (
    .tree     (plru[req_index]),
    .way      ('0),
    .tree_nxt (unused_lk_tree),
    .victim   (lk_plru_vic)
  );

  plru_tree #(.WAYS(WAYS)) u_fill_plru (
    .tree     (plru[fill_index]),
    .way      (fill_way),
    .tree_nxt (fill_tree_nxt),
    .victim   (unused_fill_vic)
  );

  // Touch for the previous cycle's hit, applied to the set's current tree.
  always_comb begin
    ht_in           = '0;
    ht_in[WAYS-2:0] = plru[upd_idx];
    ht_out          = plru_touch(WAYS, ht_in, MAX_WW'(upd_way));
  end
  assign hit_tree_nxt = ht_out[WAYS-2:0];
  assign unused_ht    = ^ht_out;

  // FSM state and flush set counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      fl_cnt <= '0;
    end else begin
      state  <= state_nxt;
      fl_cnt <= (state == FLUSH) ? fl_cnt + IDX_W'(1) : '0;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    req_ready = 1'b1;
    case (state)
      IDLE:    if (flush) state_nxt = FLUSH;
      FLUSH: begin
        busy      = 1'b1;
        req_ready = 1'b0;
        if (fl_cnt == IDX_W'(SETS-1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid and PLRU state; later assignments win: hit < fill < inv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      plru <= '0;
    end else if (state == FLUSH) begin
      vld[fl_cnt]  <= '0;
      plru[fl_cnt] <= '0;
    end else begin
      if (upd_vld) plru[upd_idx] <= hit_tree_nxt;
      if (fill_valid) begin
        vld[fill_index][fill_way] <= 1'b1;
        plru[fill_index]          <= fill_tree_nxt;
      end
      if (inv_valid) vld[inv_index] <= '0;
    end
  end

  // Tag RAM: not reset, written on accepted fills.
  always_ff @(posedge clk) begin
    if (fill_valid && state == IDLE) tags[fill_index][fill_way] <= fill_tag;
  end

  // Registered response and the pending hit touch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_victim <= '0;
      resp_multi  <= 1'b0;
      upd_vld     <= 1'b0;
      upd_idx     <= '0;
      upd_way     <= '0;
    end else begin
      resp_valid <= acc;
      upd_vld    <= acc && lk_hit;
      if (acc) begin
        resp_hit    <= lk_hit;
        resp_way    <= lk_way;
        resp_victim <= lk_victim;
        resp_multi  <= lk_multi;
        upd_idx     <= req_index;
        upd_way     <= lk_way;
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Randomized and directed bench for cache_tag_lookup against a set/way model.
module tb_cache_tag_lookup;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int TAG_W = 28;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int LVL   = $clog2(WAYS);

  logic             clk = 1'b0, rst = 1'b1;
  logic             req_valid = 0, req_ready;
  logic [IDX_W-1:0] req_index = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid, resp_hit, resp_multi;
  logic [WAY_W-1:0] resp_way, resp_victim;
  logic             fill_valid = 0;
  logic [IDX_W-1:0] fill_index = '0;
  logic [WAY_W-1:0] fill_way = '0;
  logic [TAG_W-1:0] fill_tag = '0;
  logic             inv_valid = 0;
  logic [IDX_W-1:0] inv_index = '0;
  logic             flush = 0, busy;

  cache_tag_lookup #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_victim(resp_victim), .resp_multi(resp_multi),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_valid(inv_valid), .inv_index(inv_index), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: per-set valid/tag per way, PLRU tree as an integer
  // whose bit k is heap node k (children of k are 2k+1, 2k+2).
  bit               mv [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  int               mp [SETS];
  bit               m_busy;
  int               m_cnt;
  bit               ph_v;
  int               ph_idx, ph_way;
  bit               e_rv, e_hit, e_multi;
  int               e_way, e_vic;

  function automatic int m_victim(input int t);
    int node = 0, v = 0, b;
    for (int l = 0; l < LVL; l++) begin
      b    = (t >> node) & 1;
      v    = v * 2 + b;
      node = 2 * node + 1 + b;
    end
    return v;
  endfunction

  function automatic int m_touch(input int t, input int way);
    int node = 0, b;
    for (int l = 0; l < LVL; l++) begin
      b = (way >> (LVL - 1 - l)) & 1;
      if (b != 0) t = t & ~(1 << node);
      else        t = t | (1 << node);
      node = 2 * node + 1 + b;
    end
    return t;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; mt[s][w] = '0; end
    end
    m_busy = 0; m_cnt = 0; ph_v = 0; ph_idx = 0; ph_way = 0;
    e_rv = 0; e_hit = 0; e_multi = 0; e_way = 0; e_vic = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs being sampled.
  task automatic model_step();
    bit acc;
    int hc, hw, iw;
    acc = req_valid && !m_busy;
    if (acc) begin
      hc = 0; hw = -1; iw = -1;
      for (int w = 0; w < WAYS; w++) begin
        if (mv[req_index][w] && mt[req_index][w] == req_tag) begin
          hc++;
          if (hw < 0) hw = w;
        end
        if (!mv[req_index][w] && iw < 0) iw = w;
      end
      e_hit   = hc > 0;
      e_multi = hc > 1;
      e_way   = (hw < 0) ? 0 : hw;
      e_vic   = (iw >= 0) ? iw : m_victim(mp[req_index]);
    end
    e_rv = acc;
    if (m_busy) begin
      for (int w = 0; w < WAYS; w++) mv[m_cnt][w] = 0;
      mp[m_cnt] = 0;
      if (m_cnt == SETS - 1) m_busy = 0;
      else m_cnt++;
    end else begin
      if (ph_v && !(fill_valid && int'(fill_index) == ph_idx))
        mp[ph_idx] = m_touch(mp[ph_idx], ph_way);
      if (fill_valid) begin
        mt[fill_index][fill_way] = fill_tag;
        mv[fill_index][fill_way] = 1;
        mp[fill_index] = m_touch(mp[fill_index], int'(fill_way));
      end
      if (inv_valid)
        for (int w = 0; w < WAYS; w++) mv[inv_index][w] = 0;
      if (flush) begin m_busy = 1; m_cnt = 0; end
    end
    ph_v   = acc && e_hit;
    ph_idx = int'(req_index);
    ph_way = e_way;
  endtask

  task automatic clr();
    req_valid = 0; fill_valid = 0; inv_valid = 0; flush = 0;
  endtask

  // Advance one cycle, update the model, and compare the registered outputs.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    if (e_rv) begin
      chk("resp_hit", 32'(resp_hit), 32'(e_hit));
      chk("resp_way", 32'(resp_way), 32'(e_way));
      chk("resp_victim", 32'(resp_victim), 32'(e_vic));
      chk("resp_multi", 32'(resp_multi), 32'(e_multi));
    end
    clr();
  endtask

  task automatic lookup(input int idx, input logic [TAG_W-1:0] t);
    req_valid = 1; req_index = IDX_W'(idx); req_tag = t;
    cyc();
  endtask

  task automatic fill(input int idx, input int way, input logic [TAG_W-1:0] t);
    fill_valid = 1; fill_index = IDX_W'(idx); fill_way = WAY_W'(way); fill_tag = t;
    cyc();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_hit", 32'(resp_hit), 0);
    chk("rst_resp_way", 32'(resp_way), 0);
    chk("rst_resp_victim", 32'(resp_victim), 0);
    chk("rst_resp_multi", 32'(resp_multi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
  endtask

  localparam logic [TAG_W-1:0] TAG_A = 28'hABCDEF1;
  localparam logic [TAG_W-1:0] TAG_B = 28'h0B0B0B0;
  localparam logic [TAG_W-1:0] TAG_C = 28'h0C0FFEE;

  logic [TAG_W-1:0] pool [6];

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    @(negedge clk) rst = 0;

    // First lookup after reset misses, victim way 0.
    lookup(3, 28'h1234567);
    chk("first_hit", 32'(resp_hit), 0);
    chk("first_victim", 32'(resp_victim), 0);

    // Fill then hit; way 1 still invalid so it is the victim.
    fill(3, 0, TAG_A);
    lookup(3, TAG_A);
    chk("fill_hit", 32'(resp_hit), 1);
    chk("fill_way", 32'(resp_way), 0);
    chk("fill_victim", 32'(resp_victim), 1);

    // PLRU walk on a full set.
    for (int w = 0; w < WAYS; w++) fill(5, w, 28'h500 + 28'(w));
    lookup(5, 28'h500);
    cyc();
    lookup(5, 28'h5FF);
    chk("plru_vic_a", 32'(resp_victim), 2);
    lookup(5, 28'h502);
    cyc();
    lookup(5, 28'h5FF);
    chk("plru_vic_b", 32'(resp_victim), 1);

    // Lookup concurrent with fill sees pre-fill contents.
    req_valid = 1; req_index = 7; req_tag = TAG_B;
    fill_valid = 1; fill_index = 7; fill_way = 1; fill_tag = TAG_B;
    cyc();
    chk("rbw_hit", 32'(resp_hit), 0);
    lookup(7, TAG_B);
    chk("rbw_hit_next", 32'(resp_hit), 1);
    chk("rbw_way_next", 32'(resp_way), 1);

    // Duplicate tag in two ways.
    fill(9, 2, TAG_C);
    fill(9, 0, TAG_C);
    lookup(9, TAG_C);
    chk("multi_hit", 32'(resp_hit), 1);
    chk("multi_way", 32'(resp_way), 0);
    chk("multi_flag", 32'(resp_multi), 1);

    // Full flush with a lookup accepted in the pulse cycle.
    flush = 1; req_valid = 1; req_index = 3; req_tag = TAG_A;
    cyc();
    chk("flush_pulse_resp", 32'(resp_hit), 1);
    for (int i = 0; i < SETS; i++) begin
      chk("flush_busy", 32'(busy), 1);
      req_valid = 1; req_index = 3; req_tag = TAG_A; flush = (i == 3);
      cyc();
    end
    chk("flush_done", 32'(busy), 0);
    lookup(3, TAG_A);
    chk("flush_miss", 32'(resp_hit), 0);

    // Reset during a flush.
    fill(4, 1, TAG_B);
    flush = 1;
    cyc();
    repeat (5) cyc();
    chk("midflush_busy", 32'(busy), 1);
    rst = 1;
    #1;
    model_reset();
    chk_reset_outputs();
    @(negedge clk) rst = 0;
    lookup(4, TAG_B);
    chk("midflush_cleared", 32'(resp_hit), 0);

    // Randomized traffic over a few sets and a small tag pool.
    for (int i = 0; i < 6; i++) pool[i] = TAG_W'($urandom);
    for (int n = 0; n < 3000; n++) begin
      req_valid  = ($urandom_range(0, 9) < 6);
      req_index  = IDX_W'($urandom_range(0, 3));
      req_tag    = pool[$urandom_range(0, 5)];
      fill_valid = ($urandom_range(0, 9) < 3);
      fill_index = IDX_W'($urandom_range(0, 3));
      fill_way   = WAY_W'($urandom_range(0, WAYS - 1));
      fill_tag   = pool[$urandom_range(0, 5)];
      inv_valid  = ($urandom_range(0, 19) == 0);
      inv_index  = IDX_W'($urandom_range(0, 3));
      if (inv_valid && fill_valid && inv_index == fill_index) inv_valid = 0;
      flush      = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
